// File: rtl/pearl_pipe.sv
// pearl_pipe: elastic NCHAN-way bitwise reduction carried through STAGES valid/ready registers.
// Define PEARL_PIPE_STATS_EN to add the saturating o_stall_cycles counter port.
module pearl_pipe #(
  parameter int DWIDTH = 16,
  parameter int NCHAN  = 2,
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_ena,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [NCHAN*DWIDTH-1:0]     i_data,
  input  logic [1:0]                  i_mode,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DWIDTH-1:0]           o_data,
`ifdef PEARL_PIPE_STATS_EN
  output logic [15:0]                 o_stall_cycles,
`endif
  output logic [$clog2(STAGES+1)-1:0] o_occupancy
);

  localparam int OW = $clog2(STAGES+1);

  localparam logic [1:0] MODE_AND = 2'b00;
  localparam logic [1:0] MODE_OR  = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;

  logic [DWIDTH-1:0] red_and;
  logic [DWIDTH-1:0] red_or;
  logic [DWIDTH-1:0] red_xor;
  logic [DWIDTH-1:0] red_data;

  always_comb begin
    red_and = i_data[DWIDTH-1:0];
    red_or  = i_data[DWIDTH-1:0];
    red_xor = i_data[DWIDTH-1:0];
    for (int c = 1; c < NCHAN; c++) begin
      red_and = red_and & i_data[c*DWIDTH +: DWIDTH];
      red_or  = red_or  | i_data[c*DWIDTH +: DWIDTH];
      red_xor = red_xor ^ i_data[c*DWIDTH +: DWIDTH];
    end
    red_data = i_data[DWIDTH-1:0];
    case (i_mode)
      MODE_AND: red_data = red_and;
      MODE_OR:  red_data = red_or;
      MODE_XOR: red_data = red_xor;
      default:  red_data = i_data[DWIDTH-1:0];
    endcase
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] up_v;
  logic [STAGES-1:0] rdy;
  logic [DWIDTH-1:0] data_q [STAGES];
  logic [DWIDTH-1:0] up_d   [STAGES];

  // A stage is ready if the sink is ready or any stage from here to the tail
  // holds a bubble; the flattened form avoids a combinational ripple loop.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign rdy[k] = i_ready || !(&v_q[STAGES-1:k]);
    if (k == 0) begin : g_head
      assign up_v[k] = i_valid;
      assign up_d[k] = red_data;
    end else begin : g_body
      assign up_v[k] = v_q[k-1];
      assign up_d[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else if (clk_ena) begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_q[k] <= up_v[k];
          if (up_v[k]) begin
            data_q[k] <= up_d[k];
          end
        end
      end
    end
  end

  logic accept;
  logic pop;

  assign o_ready = clk_ena && rdy[0];
  assign o_valid = clk_ena && v_q[STAGES-1];
  assign o_data  = data_q[STAGES-1];
  assign accept  = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  logic [OW-1:0] occ_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else if (accept && !pop) begin
      occ_q <= occ_q + OW'(1);
    end else if (pop && !accept) begin
      occ_q <= occ_q - OW'(1);
    end
  end

  assign o_occupancy = occ_q;

`ifdef PEARL_PIPE_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (o_valid && !i_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pearl_pipe.sv
// Self-checking bench for pearl_pipe: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pearl_pipe;

  localparam int DW = 16;
  localparam int NC = 2;
  localparam int ST = 2;
  localparam int OW = $clog2(ST+1);

  logic              clk;
  logic              reset;
  logic              clk_ena;
  logic              i_valid;
  logic              o_ready;
  logic [NC*DW-1:0]  i_data;
  logic [1:0]        i_mode;
  logic              o_valid;
  logic              i_ready;
  logic [DW-1:0]     o_data;
  logic [OW-1:0]     o_occupancy;
`ifdef PEARL_PIPE_STATS_EN
  logic [15:0]       o_stall_cycles;
`endif

  pearl_pipe #(.DWIDTH(DW), .NCHAN(NC), .STAGES(ST)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_ena        (clk_ena),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .i_mode         (i_mode),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
`ifdef PEARL_PIPE_STATS_EN
    .o_stall_cycles (o_stall_cycles),
`endif
    .o_occupancy    (o_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } item_t;

  item_t q[$];
  int    ecount    = 0;
  int    stall_exp = 0;
  int    dut_acc   = 0;
  logic  last_pop;
  logic [DW-1:0] last_pop_data;

  typedef struct {
    logic [NC*DW-1:0] data;
    logic [1:0]       mode;
    logic [DW-1:0]    exp;
  } vec_t;

  vec_t vec[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Per-bit population count across channels: all ones, any one, odd count.
  function automatic logic [DW-1:0] ref_reduce(input logic [NC*DW-1:0] d, input logic [1:0] m);
    logic [DW-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < DW; b++) begin
      ones = 0;
      for (int c = 0; c < NC; c++) ones += int'(d[c*DW+b]);
      case (m)
        2'b00:   r[b] = (ones == NC);
        2'b01:   r[b] = (ones > 0);
        2'b10:   r[b] = ((ones % 2) == 1);
        default: r[b] = d[b];
      endcase
    end
    return r;
  endfunction

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    logic exp_ready;
    logic exp_valid;
    #1;
    exp_ready = clk_ena && ((q.size() < ST) || i_ready);
    exp_valid = clk_ena && (q.size() > 0) && ((ecount - q[0].stamp - 1) >= (ST - 1));
    check("o_ready", o_ready, exp_ready);
    check("o_valid", o_valid, exp_valid);
    check("o_occupancy", o_occupancy, q.size());
    if (exp_valid) check("o_data", o_data, q[0].data);
`ifdef PEARL_PIPE_STATS_EN
    check("o_stall_cycles", o_stall_cycles, stall_exp);
`endif
    if (exp_valid && !i_ready && stall_exp != 16'hFFFF) stall_exp++;
    last_pop      = o_valid && i_ready;
    last_pop_data = o_data;
    if (i_valid && o_ready) dut_acc++;
    if (exp_valid && i_ready) void'(q.pop_front());
    if (i_valid && exp_ready) q.push_back('{ref_reduce(i_data, i_mode), ecount});
    @(posedge clk);
    if (clk_ena) ecount++;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_o_valid"}, o_valid, 1'b0);
    check({tag, "_o_data"}, o_data, '0);
    check({tag, "_o_occupancy"}, o_occupancy, '0);
    check({tag, "_o_ready"}, o_ready, clk_ena);
    q.delete();
    stall_exp = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    clk_ena = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() > 0; n++) tick();
    check({tag, "_drained"}, q.size(), 0);
    #1;
    check({tag, "_occ_empty"}, o_occupancy, '0);
    @(negedge clk);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached before completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int oi;
    int acc0;
    reset   = 1'b0;
    clk_ena = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    i_mode  = 2'b00;

    vec[0] = '{{16'h0F0F, 16'h00FF}, 2'b00, 16'h000F};
    vec[1] = '{{16'h0F0F, 16'h00FF}, 2'b01, 16'h0FFF};
    vec[2] = '{{16'h0F0F, 16'h00FF}, 2'b10, 16'h0FF0};
    vec[3] = '{{16'h0F0F, 16'h00FF}, 2'b11, 16'h00FF};
    vec[4] = '{{16'hFFFF, 16'hFFFF}, 2'b10, 16'h0000};
    vec[5] = '{{16'hAAAA, 16'h5555}, 2'b01, 16'hFFFF};
    vec[6] = '{{16'hAAAA, 16'h5555}, 2'b00, 16'h0000};
    vec[7] = '{{16'h1234, 16'hABCD}, 2'b11, 16'hABCD};

    #2;
    do_reset("rst0");

    // Streaming table with the sink always ready.
    i_ready = 1'b1;
    oi = 0;
    foreach (vec[i]) begin
      i_valid = 1'b1;
      i_data  = vec[i].data;
      i_mode  = vec[i].mode;
      tick();
      if (last_pop && oi < 8) begin check($sformatf("vec%0d", oi), last_pop_data, vec[oi].exp); oi++; end
    end
    i_valid = 1'b0;
    for (int n = 0; n < 10 && oi < 8; n++) begin
      tick();
      if (last_pop && oi < 8) begin check($sformatf("vec%0d", oi), last_pop_data, vec[oi].exp); oi++; end
    end
    check("vec_count", oi, 8);
    drain("vec");

    // Backpressure: offer four words, only STAGES fit.
    i_ready = 1'b0;
    acc0 = dut_acc;
    for (int n = 0; n < 4; n++) begin
      i_valid = 1'b1;
      i_data  = {16'h1000 + 16'(n), 16'h2000 + 16'(n)};
      i_mode  = 2'(n);
      tick();
    end
    check("bp_accepted", dut_acc - acc0, ST);
    #1;
    check("bp_full_ready", o_ready, 1'b0);
    @(negedge clk);
    drain("bp");

    // A lone word collapses to the tail while the sink stalls.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = {16'h00F0, 16'h0FF0};
    i_mode  = 2'b01;
    tick();
    i_valid = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    #1;
    check("collapse_valid", o_valid, 1'b1);
    check("collapse_ready", o_ready, 1'b1);
    check("collapse_data", o_data, 16'h0FF0);
    @(negedge clk);
    drain("collapse");

    // Freeze with two words in flight.
    i_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      i_valid = 1'b1;
      i_data  = {16'hC3C3, 16'h3C3C + 16'(n)};
      i_mode  = 2'b10;
      tick();
    end
    i_valid = 1'b0;
    clk_ena = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    #1;
    check("freeze_occ", o_occupancy, 2'd2);
    check("freeze_hold_data", o_data, 16'hFFFF);
    @(negedge clk);
    drain("freeze");

    // Asynchronous reset with two words in flight.
    i_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      i_valid = 1'b1;
      i_data  = {16'h5A5A, 16'h0001 + 16'(n)};
      i_mode  = 2'b11;
      tick();
    end
    i_valid = 1'b0;
    do_reset("rst_mid");
    i_ready = 1'b1;
    for (int n = 0; n < 4; n++) tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      clk_ena = ($urandom_range(0, 9) != 0);
      i_valid = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 3) != 0);
      i_data  = $urandom;
      i_mode  = 2'($urandom_range(0, 3));
      tick();
    end
    drain("rand");

`ifdef PEARL_PIPE_STATS_EN
    do_reset("rst_stats");
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = {16'h1111, 16'h2222};
    i_mode  = 2'b01;
    tick();
    i_valid = 1'b0;
    for (int n = 0; n < 70000; n++) tick();
    #1;
    check("stall_saturated", o_stall_cycles, 16'hFFFF);
    @(negedge clk);
    drain("stats");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
